// File: rtl/vga_digit_render.sv
// vga_digit_render: two-stage segment-digit renderer for a fixed window.
// Optional macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module vga_digit_render #(
  parameter int          NUM_DIGITS = 4,
  parameter int          X0         = 256,
  parameter int          Y0         = 216,
  parameter int          DIGIT_W    = 32,
  parameter int          DIGIT_H    = 48,
  parameter int          DIGIT_GAP  = 8,
  parameter int          SEG_T      = 4,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              num,
  input  logic [11:0]             seg0,
  input  logic [11:0]             seg1,
  input  logic [11:0]             seg2,
  input  logic [11:0]             seg3,
  input  logic [11:0]             seg4,
  input  logic [11:0]             seg5,
  input  logic [11:0]             seg6,
  input  logic [11:0]             seg7,
  input  logic [11:0]             seg8,
  output logic [11:0]             pixel
);

  localparam int PITCH = DIGIT_W + DIGIT_GAP;
  localparam int MID   = DIGIT_H / 2;
  localparam int HT    = SEG_T / 2;

  typedef enum logic [3:0] {
    R_S0, R_S1, R_S2, R_S3, R_S4,
    R_S5, R_S6, R_S7, R_S8, R_NONE
  } region_t;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [3:0]  nib;
  logic        in_box, in_gap;
  logic        left, right, xmid;
  logic        top, upper, mid, lower, bot;
  int          hi, vi, lx, ly;
  region_t     reg_d, reg_q;
  logic        lit_q, valid_q, show;
  logic [11:0] segsel;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  blank_d, blank_q;

  // flag digits that sit left of the first nonzero nibble
  always_comb begin : lzb
    logic run;
    run = 1'b1;
    blank_vec = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      run = run & (shadow[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      blank_vec[d] = run & (d != NUM_DIGITS - 1);
    end
  end
`endif

  // latch the displayed value once per frame so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (h_cnt == 10'd0 && v_cnt == 10'd0) begin
      shadow <= value;
    end
  end

  // locate digit, local coordinates and segment region of this pixel
  always_comb begin
    hi     = int'(h_cnt);
    vi     = int'(v_cnt);
    ly     = vi - Y0;
    lx     = 0;
    nib    = 4'd0;
    in_box = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d = 1'b0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (hi >= X0 + d*PITCH && hi < X0 + (d+1)*PITCH) begin
        lx     = hi - (X0 + d*PITCH);
        nib    = shadow[4*(NUM_DIGITS-1-d) +: 4];
        in_box = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d = blank_vec[d];
`endif
      end
    end
    in_box = in_box && vi >= Y0 && vi < Y0 + DIGIT_H;
    in_gap = lx >= DIGIT_W;
    left   = lx < SEG_T;
    right  = lx >= DIGIT_W - SEG_T && lx < DIGIT_W;
    xmid   = lx >= SEG_T && lx < DIGIT_W - SEG_T;
    top    = ly < SEG_T;
    upper  = ly >= SEG_T && ly < MID - HT;
    mid    = ly >= MID - HT && ly < MID + HT;
    lower  = ly >= MID + HT && ly < DIGIT_H - SEG_T;
    bot    = ly >= DIGIT_H - SEG_T;
    reg_d  = R_NONE;
    unique case (1'b1)
      xmid && top:    reg_d = R_S0;
      xmid && bot:    reg_d = R_S3;
      xmid && mid:    reg_d = R_S6;
      left && upper:  reg_d = R_S5;
      right && upper: reg_d = R_S1;
      left && lower:  reg_d = R_S4;
      right && lower: reg_d = R_S2;
      left && mid:    reg_d = R_S8;
      right && mid:   reg_d = R_S7;
      default:        reg_d = R_NONE;
    endcase
  end

  // stage 1: present the digit to the decoder, carry pixel context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num     <= 4'd0;
      reg_q   <= R_S0;
      lit_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      num     <= in_box ? nib : 4'd0;
      reg_q   <= reg_d;
      lit_q   <= in_box & ~in_gap;
      valid_q <= valid;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // pick the decoder colour for the registered region
  always_comb begin
    segsel = BG_COLOR;
`ifdef LEADING_ZERO_BLANK_EN
    show = lit_q & ~blank_q;
`else
    show = lit_q;
`endif
    case (reg_q)
      R_S0:    segsel = seg0;
      R_S1:    segsel = seg1;
      R_S2:    segsel = seg2;
      R_S3:    segsel = seg3;
      R_S4:    segsel = seg4;
      R_S5:    segsel = seg5;
      R_S6:    segsel = seg6;
      R_S7:    segsel = seg7;
      R_S8:    segsel = seg8;
      default: segsel = BG_COLOR;
    endcase
  end

  // stage 2: final registered colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel <= 12'h000;
    end else if (!valid_q) begin
      pixel <= 12'h000;
    end else if (!show) begin
      pixel <= BG_COLOR;
    end else begin
      pixel <= segsel;
    end
  end

endmodule

// File: tb/tb_vga_digit_render.sv
// tb_vga_digit_render: directed and random checks of vga_digit_render.
// Models the segment decoder and the window geometry arithmetically.
module tb_vga_digit_render;

  localparam int X0 = 256;
  localparam int Y0 = 216;
  localparam int W  = 32;
  localparam int H  = 48;
  localparam int PITCH = 40;
  localparam int T  = 4;
  localparam int M  = 24;
  localparam int HH = 2;
  localparam logic [11:0] BG = 12'h000;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  localparam int RT [5][3] = '{
    '{-1, 0, -1}, '{5, -1, 1}, '{8, 6, 7},
    '{4, -1, 2}, '{-1, 3, -1}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [15:0] value = '0;
  logic [3:0]  num;
  logic [11:0] seg0, seg1, seg2, seg3, seg4;
  logic [11:0] seg5, seg6, seg7, seg8;
  logic [11:0] pixel;

  bit          dmode = 1'b0;
  logic [15:0] msh = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] dcol(
    input logic [3:0] n, input int s, input bit md);
    logic [6:0] p;
    logic       lit;
    p   = PAT[n];
    lit = (s < 7) ? p[s] : p[6];
    if (md) return {4'(s + 1), n, lit ? 4'hf : 4'h3};
    return lit ? 12'hfff : 12'h000;
  endfunction

  assign seg0 = dcol(num, 0, dmode);
  assign seg1 = dcol(num, 1, dmode);
  assign seg2 = dcol(num, 2, dmode);
  assign seg3 = dcol(num, 3, dmode);
  assign seg4 = dcol(num, 4, dmode);
  assign seg5 = dcol(num, 5, dmode);
  assign seg6 = dcol(num, 6, dmode);
  assign seg7 = dcol(num, 7, dmode);
  assign seg8 = dcol(num, 8, dmode);

  vga_digit_render dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .value(value),
    .num(num),
    .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg3(seg3), .seg4(seg4), .seg5(seg5),
    .seg6(seg6), .seg7(seg7), .seg8(seg8),
    .pixel(pixel));

  // model the pixel, update the model shadow, then drive inputs
  task automatic apply(input int h, input int v, input bit val,
                       output logic [3:0] en,
                       output logic [11:0] ep);
    int d, lx, ly, c, r, s;
    logic [3:0] n;
    en = 4'd0;
    ep = val ? BG : 12'h000;
    if (v >= Y0 && v < Y0 + H && h >= X0 && h < X0 + 4*PITCH) begin
      d  = (h - X0) / PITCH;
      lx = (h - X0) % PITCH;
      ly = v - Y0;
      n  = msh[4*(3-d) +: 4];
      en = n;
      c  = lx < T ? 0 : lx < W - T ? 1 : lx < W ? 2 : 3;
      r  = ly < T ? 0 : ly < M - HH ? 1 : ly < M + HH ? 2 :
           ly < H - T ? 3 : 4;
      s  = (c == 3) ? -1 : RT[r][c];
`ifdef LEADING_ZERO_BLANK_EN
      if (d < 3 && (msh >> (4*(3-d))) == 16'd0) s = -1;
`endif
      if (val && s >= 0) ep = dcol(n, s, dmode);
    end
    if (h == 0 && v == 0) msh = value;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    valid = val;
  endtask

  task automatic present(input int h, input int v, input bit val,
                         output logic [3:0] en,
                         output logic [11:0] ep);
    @(negedge clk);
    apply(h, v, val, en, ep);
    @(negedge clk);
  endtask

  task automatic frame();
    logic [3:0]  a;
    logic [11:0] b;
    @(negedge clk);
    apply(0, 0, 1'b1, a, b);
  endtask

  task automatic test_reset();
    value = 16'h1234;
    valid = 1'b1;
    h_cnt = 10'd272;
    v_cnt = 10'd217;
    repeat (3) @(negedge clk);
    total++;
    if (pixel !== 12'h000) begin
      bad++;
      $display("FAIL reset_pixel: got %h want 000", pixel);
    end
    total++;
    if (num !== 4'd0) begin
      bad++;
      $display("FAIL reset_num: got %h want 0", num);
    end
    msh = 16'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int          ph [10] = '{272, 286, 312, 298, 290,
                             300, 255, 272, 405, 256};
    int          pv [10] = '{217, 226, 239, 243, 230,
                             230, 220, 264, 226, 216};
    logic [3:0]  pn [10] = '{1, 2 - 1, 2, 2, 1, 2, 0, 0, 4, 1};
    logic [11:0] pp [10] = '{12'h000, 12'hfff, 12'hfff, 12'hfff,
                             12'h000, 12'h000, 12'h000, 12'h000,
                             12'hfff, 12'h000};
    logic [3:0]  en;
    logic [11:0] ep;
    value = 16'h1234;
    frame();
    for (int i = 0; i < 10; i++) begin
      present(ph[i], pv[i], 1'b1, en, ep);
      total++;
      if (num !== pn[i]) begin
        bad++;
        $display("FAIL dir_num[%0d]: got %h want %h", i, num, pn[i]);
      end
      @(negedge clk);
      total++;
      if (pixel !== pp[i]) begin
        bad++;
        $display("FAIL dir_pix[%0d]: got %h want %h",
                 i, pixel, pp[i]);
      end
    end
  endtask

  task automatic test_frame_shadow();
    logic [3:0]  en;
    logic [11:0] ep;
    value = 16'h9999;
    present(312, 239, 1'b1, en, ep);
    total++;
    if (num !== 4'd2) begin
      bad++;
      $display("FAIL shadow_old_num: got %h want 2", num);
    end
    @(negedge clk);
    total++;
    if (pixel !== 12'hfff) begin
      bad++;
      $display("FAIL shadow_old_pix: got %h want fff", pixel);
    end
    frame();
    present(272, 262, 1'b1, en, ep);
    total++;
    if (num !== 4'd9) begin
      bad++;
      $display("FAIL shadow_new_num: got %h want 9", num);
    end
    @(negedge clk);
    total++;
    if (pixel !== 12'hfff) begin
      bad++;
      $display("FAIL shadow_new_pix: got %h want fff", pixel);
    end
  endtask

  task automatic test_valid_and_async_reset();
    logic [3:0]  en;
    logic [11:0] ep;
    logic [11:0] want;
    present(272, 262, 1'b0, en, ep);
    @(negedge clk);
    total++;
    if (pixel !== 12'h000) begin
      bad++;
      $display("FAIL invalid_pix: got %h want 000", pixel);
    end
    present(272, 262, 1'b1, en, ep);
    @(negedge clk);
    total++;
    if (pixel !== 12'hfff) begin
      bad++;
      $display("FAIL pre_reset_pix: got %h want fff", pixel);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pixel !== 12'h000 || num !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: got pix=%h num=%h want 000/0",
               pixel, num);
    end
    msh = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    present(272, 217, 1'b1, en, ep);
    @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    want = 12'h000;
`else
    want = 12'hfff;
`endif
    total++;
    if (pixel !== want) begin
      bad++;
      $display("FAIL post_reset_d0: got %h want %h", pixel, want);
    end
    present(392, 217, 1'b1, en, ep);
    @(negedge clk);
    total++;
    if (pixel !== 12'hfff) begin
      bad++;
      $display("FAIL post_reset_d3: got %h want fff", pixel);
    end
  endtask

  task automatic test_blank();
    int          bh [6] = '{272, 312, 352, 392, 352, 392};
    logic [15:0] bv [6] = '{16'h0042, 16'h0042, 16'h0042,
                            16'h0042, 16'h0000, 16'h0000};
    logic [3:0]  bn [6] = '{0, 0, 4, 2, 0, 0};
`ifdef LEADING_ZERO_BLANK_EN
    logic [11:0] bp [6] = '{12'h000, 12'h000, 12'h000,
                            12'hfff, 12'h000, 12'hfff};
`else
    logic [11:0] bp [6] = '{12'hfff, 12'hfff, 12'h000,
                            12'hfff, 12'hfff, 12'hfff};
`endif
    logic [3:0]  en;
    logic [11:0] ep;
    for (int i = 0; i < 6; i++) begin
      if (value !== bv[i]) begin
        value = bv[i];
        frame();
      end
      present(bh[i], 217, 1'b1, en, ep);
      total++;
      if (num !== bn[i]) begin
        bad++;
        $display("FAIL blank_num[%0d]: got %h want %h",
                 i, num, bn[i]);
      end
      @(negedge clk);
      total++;
      if (pixel !== bp[i]) begin
        bad++;
        $display("FAIL blank_pix[%0d]: got %h want %h",
                 i, pixel, bp[i]);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 3000;
    logic [3:0]  en_h [N];
    logic [11:0] ep_h [N];
    int h, v;
    bit val;
    dmode = 1'b1;
    value = 16'(($urandom));
    frame();
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= N) begin
        total++;
        if (num !== en_h[i-1]) begin
          bad++;
          $display("FAIL rnd_num[%0d]: got %h want %h",
                   i - 1, num, en_h[i-1]);
        end
      end
      if (i >= 2) begin
        total++;
        if (pixel !== ep_h[i-2]) begin
          bad++;
          $display("FAIL rnd_pix[%0d]: got %h want %h",
                   i - 2, pixel, ep_h[i-2]);
        end
      end
      if (i < N) begin
        h   = int'($urandom_range(250, 420));
        v   = int'($urandom_range(210, 270));
        val = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) begin
          value = 16'(($urandom));
          h = 0;
          v = 0;
        end
        apply(h, v, val, en_h[i], ep_h[i]);
      end
    end
    dmode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_frame_shadow();
    test_valid_and_async_reset();
    test_blank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
